gmii_tx_framer: RTL and testbench

- Ethernet transmit framer that drives the GMII transmit side of the RGMII bridge (gmii_txd / gmii_tx_en / gmii_tx_er), all in the gmii_tx_clk domain.
- Accepts raw frame bytes (DA..payload) on a valid/ready/last byte stream.
- Emits preamble, SFD, payload, minimum-length padding and CRC32 FCS, then enforces the inter-frame gap.
- Aborts cleanly on source underrun.

---
 rtl/eth_pkg.sv | 20 ++
 rtl/crc32_d8.sv | 21 ++
 rtl/gmii_tx_framer.sv | 178 +++++++++++++++++
 tb/tb_gmii_tx_framer.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_pkg.sv
// Shared Ethernet constants and the transmit framer state encoding.
package eth_pkg;

  localparam logic [7:0]  ETH_PREAMBLE    = 8'h55;
  localparam logic [7:0]  ETH_SFD         = 8'hD5;
  localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT      = 32'hFFFFFFFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_SFD,
    ST_DATA,
    ST_PAD,
    ST_FCS,
    ST_IFG,
    ST_DISCARD
  } tx_state_e;

endpackage

// File: rtl/crc32_d8.sv
// Combinational byte-wide step of the reflected IEEE 802.3 CRC32 (data LSB first).
module crc32_d8
  import eth_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [7:0]  data,
  output logic [31:0] crc_out
);

  logic [31:0] c;

  always_comb begin
    c = crc_in ^ {24'h000000, data};
    for (int i = 0; i < 8; i++) begin
      if (c[0]) c = {1'b0, c[31:1]} ^ CRC32_POLY_REFL;
      else      c = {1'b0, c[31:1]};
    end
    crc_out = c;
  end

endmodule

// File: rtl/gmii_tx_framer.sv
// GMII transmit framer: preamble/SFD, payload, zero padding, FCS, inter-frame gap,
// with a single-cycle tx_er abort when the byte source underruns mid-frame.
module gmii_tx_framer
  import eth_pkg::*;
#(
  parameter int PREAMBLE_LEN = 7,
  parameter int MIN_FRAME    = 60,
  parameter int PAD_EN       = 1,
  parameter int IFG_BYTES    = 12
) (
  input  logic        gmii_tx_clk,
  input  logic        reset,
  input  logic [7:0]  s_data,
  input  logic        s_valid,
  input  logic        s_last,
  output logic        s_ready,
  output logic [7:0]  gmii_txd,
  output logic        gmii_tx_en,
  output logic        gmii_tx_er,
  output logic        busy,
  output logic [15:0] frame_cnt,
  output logic [15:0] underrun_cnt
);

  localparam logic [15:0] PRE_LAST  = 16'(PREAMBLE_LEN - 1);
  localparam logic [15:0] IFG_LAST  = 16'(IFG_BYTES - 1);
  localparam logic [15:0] MIN_LEN   = 16'(MIN_FRAME);

  tx_state_e   state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] byte_cnt_q, byte_cnt_d, byte_inc;
  logic [31:0] crc_q, crc_d, crc_next, fcs_word;
  logic [7:0]  crc_data;
  logic [7:0]  txd_q, txd_d;
  logic        tx_en_q, tx_en_d;
  logic        tx_er_q, tx_er_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic [15:0] underrun_cnt_q, underrun_cnt_d;

  // Padding bytes are zero, so the CRC input is only the source byte while in DATA.
  assign crc_data = (state_q == ST_DATA) ? s_data : 8'h00;
  assign byte_inc = (byte_cnt_q == 16'hFFFF) ? byte_cnt_q : byte_cnt_q + 16'd1;
  assign fcs_word = ~crc_q;

  crc32_d8 u_crc (
    .crc_in  (crc_q),
    .data    (crc_data),
    .crc_out (crc_next)
  );

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    byte_cnt_d     = byte_cnt_q;
    crc_d          = crc_q;
    txd_d          = 8'h00;
    tx_en_d        = 1'b0;
    tx_er_d        = 1'b0;
    frame_cnt_d    = frame_cnt_q;
    underrun_cnt_d = underrun_cnt_q;
    s_ready        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (s_valid) begin
          state_d = ST_PRE;
          cnt_d   = 16'd0;
        end
      end
      ST_PRE: begin
        txd_d   = ETH_PREAMBLE;
        tx_en_d = 1'b1;
        if (cnt_q == PRE_LAST) state_d = ST_SFD;
        else                   cnt_d   = cnt_q + 16'd1;
      end
      ST_SFD: begin
        txd_d      = ETH_SFD;
        tx_en_d    = 1'b1;
        crc_d      = CRC32_INIT;
        byte_cnt_d = 16'd0;
        state_d    = ST_DATA;
      end
      ST_DATA: begin
        s_ready = 1'b1;
        tx_en_d = 1'b1;
        if (s_valid) begin
          txd_d      = s_data;
          crc_d      = crc_next;
          byte_cnt_d = byte_inc;
          if (s_last) begin
            cnt_d = 16'd0;
            if ((PAD_EN != 0) && (byte_inc < MIN_LEN)) state_d = ST_PAD;
            else                                       state_d = ST_FCS;
          end
        end else begin
          // Source ran dry mid-frame: poison the frame on the wire for one byte time.
          tx_er_d = 1'b1;
          if (underrun_cnt_q != 16'hFFFF) underrun_cnt_d = underrun_cnt_q + 16'd1;
          state_d = ST_DISCARD;
        end
      end
      ST_PAD: begin
        tx_en_d    = 1'b1;
        crc_d      = crc_next;
        byte_cnt_d = byte_inc;
        if (byte_inc >= MIN_LEN) begin
          state_d = ST_FCS;
          cnt_d   = 16'd0;
        end
      end
      ST_FCS: begin
        tx_en_d = 1'b1;
        case (cnt_q[1:0])
          2'd0:    txd_d = fcs_word[7:0];
          2'd1:    txd_d = fcs_word[15:8];
          2'd2:    txd_d = fcs_word[23:16];
          default: txd_d = fcs_word[31:24];
        endcase
        if (cnt_q[1:0] == 2'd3) begin
          frame_cnt_d = frame_cnt_q + 16'd1;
          state_d     = ST_IFG;
          cnt_d       = 16'd0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_IFG: begin
        // A waiting frame starts straight from here so the gap is exactly IFG_BYTES.
        if (cnt_q == IFG_LAST) begin
          state_d = s_valid ? ST_PRE : ST_IDLE;
          cnt_d   = 16'd0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_DISCARD: begin
        s_ready = 1'b1;
        if (s_valid && s_last) begin
          state_d = ST_IFG;
          cnt_d   = 16'd0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge gmii_tx_clk or posedge reset) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      cnt_q          <= 16'd0;
      byte_cnt_q     <= 16'd0;
      crc_q          <= CRC32_INIT;
      txd_q          <= 8'h00;
      tx_en_q        <= 1'b0;
      tx_er_q        <= 1'b0;
      frame_cnt_q    <= 16'd0;
      underrun_cnt_q <= 16'd0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      byte_cnt_q     <= byte_cnt_d;
      crc_q          <= crc_d;
      txd_q          <= txd_d;
      tx_en_q        <= tx_en_d;
      tx_er_q        <= tx_er_d;
      frame_cnt_q    <= frame_cnt_d;
      underrun_cnt_q <= underrun_cnt_d;
    end
  end

  assign gmii_txd     = txd_q;
  assign gmii_tx_en   = tx_en_q;
  assign gmii_tx_er   = tx_er_q;
  assign busy         = (state_q != ST_IDLE);
  assign frame_cnt    = frame_cnt_q;
  assign underrun_cnt = underrun_cnt_q;

endmodule

// File: tb/tb_gmii_tx_framer.sv
// Directed bench: a padding and a non-padding framer share one byte source; a monitor
// captures every tx_en byte and compares it to a bit-serial software CRC frame model.
module tb_gmii_tx_framer;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  s_data;
  logic        s_valid;
  logic        s_last;
  int          sel;

  logic        sv_p, rdy_p, en_p, er_p, busy_p;
  logic        sv_n, rdy_n, en_n, er_n, busy_n;
  logic [7:0]  txd_p, txd_n;
  logic [15:0] fc_p, uc_p, fc_n, uc_n;

  logic        s_ready_m, en_m, er_m, busy_m;
  logic [7:0]  txd_m;
  logic [15:0] fc_m, uc_m;

  always #4 clk = ~clk;

  assign sv_p      = s_valid && (sel == 0);
  assign sv_n      = s_valid && (sel == 1);
  assign s_ready_m = (sel == 0) ? rdy_p  : rdy_n;
  assign en_m      = (sel == 0) ? en_p   : en_n;
  assign er_m      = (sel == 0) ? er_p   : er_n;
  assign busy_m    = (sel == 0) ? busy_p : busy_n;
  assign txd_m     = (sel == 0) ? txd_p  : txd_n;
  assign fc_m      = (sel == 0) ? fc_p   : fc_n;
  assign uc_m      = (sel == 0) ? uc_p   : uc_n;

  gmii_tx_framer #(.PAD_EN(1)) dut_p (
    .gmii_tx_clk(clk), .reset(reset), .s_data(s_data), .s_valid(sv_p), .s_last(s_last),
    .s_ready(rdy_p), .gmii_txd(txd_p), .gmii_tx_en(en_p), .gmii_tx_er(er_p),
    .busy(busy_p), .frame_cnt(fc_p), .underrun_cnt(uc_p)
  );

  gmii_tx_framer #(.PAD_EN(0)) dut_n (
    .gmii_tx_clk(clk), .reset(reset), .s_data(s_data), .s_valid(sv_n), .s_last(s_last),
    .s_ready(rdy_n), .gmii_txd(txd_n), .gmii_tx_en(en_n), .gmii_tx_er(er_n),
    .busy(busy_n), .frame_cnt(fc_n), .underrun_cnt(uc_n)
  );

  // ---------------- monitor ----------------
  logic [7:0] cap[$];
  logic [7:0] expq[$];
  int rises, gap, last_gap, er_cnt, er_bad, er_idx, ready_cycles;
  bit prev_en;

  always @(negedge clk) begin
    if (er_m) begin
      er_cnt++;
      er_idx = cap.size();
      if (!en_m || txd_m != 8'h00) er_bad++;
    end
    if (en_m) begin
      cap.push_back(txd_m);
      if (!prev_en) begin
        rises++;
        last_gap = gap;
      end
      gap = 0;
    end else begin
      gap++;
    end
    if (s_ready_m) ready_cycles++;
    prev_en = en_m;
  end

  task automatic clear_mon();
    cap.delete();
    expq.delete();
    rises = 0; gap = 0; last_gap = -1; er_cnt = 0; er_bad = 0; er_idx = -1;
    ready_cycles = 0; prev_en = 1'b0;
  endtask

  // ---------------- checking ----------------
  int passed = 0;
  int total  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  function automatic logic [7:0] dbyte(input int k);
    return 8'h31 + k[7:0];
  endfunction

  function automatic logic [31:0] crc_upd(input logic [31:0] c_in, input logic [7:0] d);
    logic [31:0] c;
    logic fb;
    c = c_in;
    for (int k = 0; k < 8; k++) begin
      fb = c[0] ^ d[k];
      c  = {1'b0, c[31:1]};
      if (fb) c = c ^ 32'hEDB88320;
    end
    return c;
  endfunction

  task automatic add_hdr();
    for (int k = 0; k < 7; k++) expq.push_back(8'h55);
    expq.push_back(8'hD5);
  endtask

  task automatic add_exp(input int len, input bit pad);
    logic [31:0] c;
    logic [7:0]  b;
    int n;
    c = 32'hFFFFFFFF;
    add_hdr();
    n = (pad && len < 60) ? 60 : len;
    for (int k = 0; k < n; k++) begin
      b = (k < len) ? dbyte(k) : 8'h00;
      expq.push_back(b);
      c = crc_upd(c, b);
    end
    c = ~c;
    expq.push_back(c[7:0]);
    expq.push_back(c[15:8]);
    expq.push_back(c[23:16]);
    expq.push_back(c[31:24]);
  endtask

  task automatic add_abort(input int nbytes);
    add_hdr();
    for (int k = 0; k < nbytes; k++) expq.push_back(dbyte(k));
    expq.push_back(8'h00);
  endtask

  task automatic cmp_frame(input string nm);
    int mism;
    mism = 0;
    for (int k = 0; k < cap.size() && k < expq.size(); k++)
      if (cap[k] !== expq[k]) mism++;
    chk({nm, "_len"}, cap.size(), expq.size());
    chk({nm, "_bytes"}, mism, 0);
  endtask

  task automatic send(input int len, input int hole_at, input int hole_len);
    int i, holes, guard;
    bit acc;
    i = 0; holes = hole_len; guard = 0;
    s_data = dbyte(0); s_last = (len == 1); s_valid = 1'b1;
    while (i < len && guard < 4000) begin
      @(negedge clk);
      acc = s_valid && s_ready_m;
      @(posedge clk); #1;
      guard++;
      if (acc) i++;
      if (i == hole_at && holes > 0) begin
        s_valid = 1'b0;
        holes--;
      end else begin
        s_valid = (i < len);
        s_data  = dbyte(i);
        s_last  = (i == len - 1);
      end
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    chk("send_complete", i, len);
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy_m && n < 4000);
    chk({nm, "_idle"}, busy_m, 1'b0);
    repeat (2) @(negedge clk);
  endtask

  typedef struct {
    int nopad;
    int len;
    int run;
  } vec_t;

  vec_t vt[6];
  int   exp_fc[2];

  initial begin
    vt[0] = '{nopad: 1, len: 9,  run: 21};
    vt[1] = '{nopad: 0, len: 14, run: 72};
    vt[2] = '{nopad: 0, len: 60, run: 72};
    vt[3] = '{nopad: 0, len: 61, run: 73};
    vt[4] = '{nopad: 0, len: 1,  run: 72};
    vt[5] = '{nopad: 1, len: 1,  run: 13};
    exp_fc[0] = 0; exp_fc[1] = 0;

    sel = 0; s_valid = 1'b0; s_last = 1'b0; s_data = 8'h00;
    reset = 1'b1;
    clear_mon();
    repeat (3) @(negedge clk);
    chk("rst_txd", txd_m, 8'h00);
    chk("rst_en", en_m, 1'b0);
    chk("rst_er", er_m, 1'b0);
    chk("rst_ready", s_ready_m, 1'b0);
    chk("rst_busy", busy_m, 1'b0);
    chk("rst_fc", fc_m, 16'h0000);
    chk("rst_uc", uc_m, 16'h0000);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // table-driven single frames
    for (int v = 0; v < 6; v++) begin
      sel = vt[v].nopad;
      clear_mon();
      send(vt[v].len, -1, 0);
      wait_idle("vec");
      add_exp(vt[v].len, vt[v].nopad == 0);
      exp_fc[sel]++;
      $display("vec %0d: pad_en=%0d len=%0d tx_en run=%0d frame_cnt=%0d",
               v, 1 - vt[v].nopad, vt[v].len, cap.size(), fc_m);
      chk("vec_run", cap.size(), vt[v].run);
      chk("vec_rises", rises, 1);
      cmp_frame("vec_frame");
      chk("vec_frame_cnt", fc_m, exp_fc[sel]);
      if (v == 0) chk("check_fcs", {cap[20], cap[19], cap[18], cap[17]}, 32'hCBF43926);
    end

    // two 64-byte frames back to back
    sel = 0;
    clear_mon();
    send(64, -1, 0);
    send(64, -1, 0);
    wait_idle("b2b");
    add_exp(64, 1'b1);
    add_exp(64, 1'b1);
    exp_fc[0] += 2;
    $display("b2b: bytes=%0d gap=%0d ready_cycles=%0d", cap.size(), last_gap, ready_cycles);
    cmp_frame("b2b");
    chk("b2b_rises", rises, 2);
    chk("b2b_gap", last_gap, 12);
    chk("b2b_ready_cycles", ready_cycles, 128);
    chk("b2b_frame_cnt", fc_m, exp_fc[0]);

    // underrun at byte 20 of 100, then a normal frame
    clear_mon();
    send(100, 20, 3);
    send(14, -1, 0);
    wait_idle("urun");
    add_abort(20);
    add_exp(14, 1'b1);
    exp_fc[0]++;
    $display("underrun: bytes=%0d er=%0d er_idx=%0d gap=%0d uc=%0d", cap.size(), er_cnt, er_idx,
             last_gap, uc_m);
    cmp_frame("urun");
    chk("urun_er_cnt", er_cnt, 1);
    chk("urun_er_bad", er_bad, 0);
    chk("urun_er_idx", er_idx, 28);
    chk("urun_rises", rises, 2);
    chk("urun_gap_ge_ifg", (last_gap >= 13), 1'b1);
    chk("urun_uc", uc_m, 16'd1);
    chk("urun_frame_cnt", fc_m, exp_fc[0]);

    // reset while the FCS is on the wire
    clear_mon();
    send(60, -1, 0);
    @(posedge clk); #2;
    chk("fcs_before_rst_en", en_m, 1'b1);
    reset = 1'b1;
    #1;
    chk("midrst_en", en_m, 1'b0);
    chk("midrst_er", er_m, 1'b0);
    chk("midrst_txd", txd_m, 8'h00);
    chk("midrst_busy", busy_m, 1'b0);
    chk("midrst_fc", fc_m, 16'h0000);
    $display("reset in FCS: en=%0d txd=0x%0h busy=%0d", en_m, txd_m, busy_m);
    @(negedge clk);
    reset = 1'b0;
    exp_fc[0] = 0; exp_fc[1] = 0;
    repeat (2) @(negedge clk);
    clear_mon();
    send(60, -1, 0);
    wait_idle("post_rst");
    add_exp(60, 1'b1);
    exp_fc[0]++;
    $display("post-reset frame: bytes=%0d frame_cnt=%0d", cap.size(), fc_m);
    cmp_frame("post_rst");
    chk("post_rst_fc", fc_m, exp_fc[0]);

    // counter wrap and saturation
    @(negedge clk);
    force dut_p.frame_cnt_q = 16'hFFFF;
    #1 release dut_p.frame_cnt_q;
    clear_mon();
    send(1, -1, 0);
    wait_idle("wrap");
    $display("wrap: frame_cnt=%0d", fc_m);
    chk("fc_wrap", fc_m, 16'h0000);
    @(negedge clk);
    force dut_p.underrun_cnt_q = 16'hFFFF;
    #1 release dut_p.underrun_cnt_q;
    clear_mon();
    send(30, 5, 1);
    wait_idle("sat");
    $display("saturate: underrun_cnt=0x%0h frame_cnt=%0d", uc_m, fc_m);
    chk("uc_saturate", uc_m, 16'hFFFF);
    chk("sat_fc_unchanged", fc_m, 16'h0000);
    chk("sat_er_cnt", er_cnt, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
